// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor that computes diff = a - b - borrow_in over WIDTH
// clocks, least significant bit first. It uses one full-subtractor cell and a
// registered borrow. The result can optionally saturate to zero on underflow.
// A start/busy/done handshake sequences each operation. The block targets
// control-path datapaths where area matters more than latency.
//
// Timing: start is accepted at edge k. The edges k+1 .. k+WIDTH each process
// one bit. done is high during the cycle that follows edge k+WIDTH. One
// operation completes every WIDTH+2 cycles.
//
// Parameters
//   WIDTH       operand/result width in bits, 1..64
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       operation request, sampled only while idle
//   a, b        minuend and subtrahend, captured when start is accepted
//   borrow_in   initial borrow, captured when start is accepted
//   sat_en      saturate-to-zero on underflow, captured when start is accepted
//   busy        high from the cycle after acceptance until done drops
//   done        one-cycle pulse; diff/borrow_out/zero are valid from here on
//   diff        registered result (after saturation)
//   borrow_out  final borrow, 1 = underflow
//   zero        high when the delivered diff is 0
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  input  logic             sat_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  // A 1-bit instance still needs a 1-bit counter, because $clog2(1) is 0.
  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // Operand shift registers: bit 0 always holds the bit being processed.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Partial result. Each new bit enters at the MSB end, so after WIDTH
  // shifts the LSB-first stream sits in natural bit order.
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;
  logic             r_sat;

  // Delivered result. It is updated only on the final RUN edge.
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_zero;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d_bit;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_result;

  // ---------------------------------------------------------------------------
  // Full-subtractor cell
  // ---------------------------------------------------------------------------
  assign w_a_bit   = r_a[0];
  assign w_b_bit   = r_b[0];
  assign w_d_bit   = w_a_bit ^ w_b_bit ^ r_br;
  assign w_br_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);
  assign w_last    = (r_cnt == LAST_BIT);

  // The shift-in is written as a shift plus an MSB overwrite. This form
  // covers WIDTH = 1 without a zero-width slice.
  always_comb begin
    // NOTE: default-assign every always_comb output on entry so that no path
    // leaves it unassigned; an unassigned path infers a latch.
    w_res_next            = r_res >> 1;
    w_res_next[WIDTH-1]   = w_d_bit;
  end

  // Saturation uses the borrow leaving the final bit. That borrow is the
  // underflow flag of the whole operation.
  assign w_result = (r_sat && w_br_next) ? '0 : w_res_next;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential blocks use non-blocking assignments only. Every
    // register then samples pre-edge values, whatever the statement order.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:              w_state_next = S_IDLE;
      default:             w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_IDLE:  ;
      S_RUN:   busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every datapath register is cleared, not only the control
      // state. The result registers are visible at the ports, and a clean
      // reset keeps the abort behaviour deterministic.
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_cnt        <= '0;
      r_br         <= 1'b0;
      r_sat        <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= borrow_in;
            r_sat <= sat_en;
            r_cnt <= '0;
            r_res <= '0;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff       <= w_result;
            r_borrow_out <= w_br_next;
            r_zero       <= (w_result == '0);
          end
        end
        S_DONE:  ;
        default: ;
      endcase
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  assign zero       = r_zero;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised, bit-serial WIDTH-bit subtractor. Computes diff = a - b - borrow_in one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Generalises the team's combinational half subtractor with:
  - arbitrary width
  - borrow-in chaining
  - optional saturation to zero on underflow
  - start/busy/done handshake
- Intended as a low-area arithmetic unit for control-path datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- borrow_in  input  1  initial borrow; captured on accepted start.
- sat_en  input  1  saturation mode; captured on accepted start.
- busy  output  1  high while an operation is in progress (RUN or DONE state).
- done  output  1  one-cycle pulse; result outputs are valid.
- diff  output  WIDTH  registered result.
- borrow_out  output  1  final borrow (1 = underflow).
- zero  output  1  high when the delivered diff equals 0.

Behaviour:
- Reset: one clock only; reset is synchronous and active-high. rst high at a rising edge forces the following, overriding all other inputs including start:
  - state = IDLE
  - busy = 0, done = 0
  - diff = 0, borrow_out = 0, zero = 0
  - internal shift registers, bit counter and borrow register cleared
- State machine: IDLE, RUN, DONE.
  - IDLE: on an edge with start = 1, go to RUN.
    - Capture a, b, sat_en.
    - Load borrow register with borrow_in.
    - Clear bit counter.
    - start = 0 stays in IDLE.
  - RUN: each edge processes bit i = counter.
    - d_i = a_i XOR b_i XOR br.
    - br_next = (NOT a_i AND b_i) OR (NOT (a_i XOR b_i) AND br).
    - d_i shifts into the result register MSB end. Operand registers shift right. Counter increments.
    - On the edge processing bit WIDTH-1, go to DONE. On that same edge, write diff, borrow_out and zero.
  - DONE: done = 1 for exactly this one cycle; the next edge returns to IDLE.
- Latency:
  - start sampled at edge k; done high during the cycle following edge k+WIDTH.
  - Throughput is one operation per WIDTH+2 cycles.
  - busy is high from the cycle after edge k until done deasserts.
- Saturation: if captured sat_en = 1 and final borrow = 1, diff = 0 and borrow_out = 1. Otherwise diff is the raw modulo-2^WIDTH result.
- zero is computed on the delivered diff, i.e. after saturation.
- diff, borrow_out and zero hold their values until the next completion or reset. They do not change during RUN.
- start while busy is ignored: no queueing and no effect on the current operation.
- Changes on a, b, borrow_in, sat_en outside the accepting edge have no effect.
- start held continuously: a new operation is accepted on the first IDLE edge after DONE.
- Reset mid-RUN or in DONE aborts the operation with no done pulse; outputs return to reset values.
- WIDTH = 1 degenerates to a registered full subtractor. With borrow_in = 0 it matches the half subtractor truth table.

Test Plan:
- Reset: hold rst 2 cycles with start = 1 -> busy = 0, done = 0, diff = 0x00, borrow_out = 0, zero = 0; no operation accepted.
- WIDTH = 8, a = 0x2D, b = 0x0F, borrow_in = 0, sat_en = 0, start pulsed at edge k -> done high exactly in the cycle after edge k+8; diff = 0x1E, borrow_out = 0, zero = 0; busy high for 9 cycles.
- a = 0x05, b = 0x07:
  - sat_en = 0 -> diff = 0xFE, borrow_out = 1.
  - Repeat with sat_en = 1 -> diff = 0x00, borrow_out = 1, zero = 1.
- a = 0x10, b = 0x10, borrow_in = 1 -> diff = 0xFF, borrow_out = 1. Same operands with borrow_in = 0 -> diff = 0x00, zero = 1.
- Start a = 0x80, b = 0x01. During RUN, re-pulse start and change a to 0x00 -> result diff = 0x7F, borrow_out = 0; exactly one done pulse.
- Assert rst for one cycle at bit 4 of a run -> no done; outputs 0. WIDTH = 1 instance fed all four {a, b} pairs with borrow_in = 0 -> (diff, borrow) = (0,0), (1,1), (1,0), (0,0).
